// File: rtl/mac_tx_frame_fifo.sv
// ----------------------------------------------------------------------------
// mac_tx_frame_fifo
//
// Store-and-forward TX FIFO between the frame builder and the MAC TX engine.
// Whole frames are buffered with a per-entry last-byte flag. The reader only
// sees committed frames. A partial frame can be aborted explicitly, and it is
// discarded automatically when a byte of it is dropped on overflow.
//
// Parameters
//   DATA_W        data width in bits
//   ADDR_W        log2 of depth; DEPTH = 2**ADDR_W entries, all usable
//   AFULL_THRESH  afull asserts when working level >= this value
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-high
//   wr_data      in   write byte
//   wr_en        in   write request
//   wr_last      in   byte is the last of its frame; commits the frame
//   wr_abort     in   discard the uncommitted partial frame
//   full         out  working level == DEPTH
//   afull        out  working level >= AFULL_THRESH
//   overflow     out  1-cycle pulse: write attempted while full
//   rd_en        in   read request
//   rd_data      out  read byte, registered
//   rd_last      out  rd_data is the last byte of its frame
//   rd_valid     out  rd_data/rd_last valid this cycle
//   empty        out  no committed byte available
//   frame_count  out  committed frames not yet fully read
//   level        out  working level (entries incl. uncommitted)
// ----------------------------------------------------------------------------
module mac_tx_frame_fifo #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned ADDR_W       = 7,
   parameter int unsigned AFULL_THRESH = 120
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic              wr_last,
   input  logic              wr_abort,
   output logic              full,
   output logic              afull,
   output logic              overflow,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              rd_valid,
   output logic              empty,
   output logic [ADDR_W:0]   frame_count,
   output logic [ADDR_W:0]   level
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   // Pointers carry one extra MSB so that full (level == DEPTH) and empty
   // (equal pointers) remain distinguishable.
   typedef logic [ADDR_W:0]   ptr_t;
   typedef logic [DATA_W:0]   entry_t;   // {last, data}

   localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
   localparam ptr_t AFULL_P  = ptr_t'(AFULL_THRESH);

   entry_t mem [DEPTH];

   ptr_t              rd_ptr_q, rd_ptr_d;
   ptr_t              wr_ptr_q, wr_ptr_d;   // working pointer, incl. partial frame
   ptr_t              cm_ptr_q, cm_ptr_d;   // end of last committed frame
   ptr_t              frame_count_q, frame_count_d;
   logic              bad_q, bad_d;         // current partial frame lost a byte
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_last_q, rd_last_d;
   logic              rd_valid_q, rd_valid_d;

   logic              mem_we;
   logic              commit;
   logic              rd_accept;
   entry_t            rd_entry;
   ptr_t              level_w;

   assign level_w   = wr_ptr_q - rd_ptr_q;
   assign full      = (level_w == DEPTH_P);
   assign afull     = (level_w >= AFULL_P);
   assign empty     = (rd_ptr_q == cm_ptr_q);
   assign level     = level_w;
   assign rd_entry  = mem[rd_ptr_q[ADDR_W-1:0]];
   assign rd_accept = rd_en & ~empty;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every signal gets a default at the top of the block so no path
   // leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      cm_ptr_d      = cm_ptr_q;
      bad_d         = bad_q;
      overflow_d    = 1'b0;
      mem_we        = 1'b0;
      commit        = 1'b0;
      rd_ptr_d      = rd_ptr_q;
      rd_data_d     = rd_data_q;
      rd_last_d     = rd_last_q;
      rd_valid_d    = 1'b0;
      frame_count_d = frame_count_q;

      // Write side. Abort wins over any write in the same cycle.
      if (wr_abort) begin
         wr_ptr_d = cm_ptr_q;
         bad_d    = 1'b0;
      end else if (wr_en) begin
         if (full) begin
            overflow_d = 1'b1;
            if (wr_last) begin
               // Frame already lost a byte: its end discards it.
               wr_ptr_d = cm_ptr_q;
               bad_d    = 1'b0;
            end else begin
               bad_d = 1'b1;
            end
         end else if (wr_last && bad_q) begin
            wr_ptr_d = cm_ptr_q;
            bad_d    = 1'b0;
         end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (wr_last) begin
               cm_ptr_d = wr_ptr_q + ptr_t'(1);
               commit   = 1'b1;
            end
         end
      end

      // Read side: registered output, one cycle latency.
      if (rd_accept) begin
         rd_data_d  = rd_entry[DATA_W-1:0];
         rd_last_d  = rd_entry[DATA_W];
         rd_valid_d = 1'b1;
         rd_ptr_d   = rd_ptr_q + ptr_t'(1);
      end

      // Commit and final-byte read in one cycle cancel out.
      case ({commit, rd_accept & rd_entry[DATA_W]})
         2'b10:   frame_count_d = frame_count_q + ptr_t'(1);
         2'b01:   frame_count_d = frame_count_q - ptr_t'(1);
         default: frame_count_d = frame_count_q;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         cm_ptr_q      <= '0;
         frame_count_q <= '0;
         bad_q         <= 1'b0;
         overflow_q    <= 1'b0;
         rd_data_q     <= '0;
         rd_last_q     <= 1'b0;
         rd_valid_q    <= 1'b0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         cm_ptr_q      <= cm_ptr_d;
         frame_count_q <= frame_count_d;
         bad_q         <= bad_d;
         overflow_q    <= overflow_d;
         rd_data_q     <= rd_data_d;
         rd_last_q     <= rd_last_d;
         rd_valid_q    <= rd_valid_d;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are meaningful, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr_q[ADDR_W-1:0]] <= {wr_last, wr_data};
      end
   end

   assign overflow    = overflow_q;
   assign rd_data     = rd_data_q;
   assign rd_last     = rd_last_q;
   assign rd_valid    = rd_valid_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mac_tx_frame_fifo.sv
// ----------------------------------------------------------------------------
// tb_mac_tx_frame_fifo
//
// Directed testbench for mac_tx_frame_fifo with default parameters
// (DATA_W=8, ADDR_W=7, AFULL_THRESH=120). Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_mac_tx_frame_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       wr_last;
   logic       wr_abort;
   logic       full;
   logic       afull;
   logic       overflow;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_last;
   logic       rd_valid;
   logic       empty;
   logic [7:0] frame_count;
   logic [7:0] level;

   int n_checks = 0;
   int n_fail   = 0;

   mac_tx_frame_fifo #(
      .DATA_W      (8),
      .ADDR_W      (7),
      .AFULL_THRESH(120)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .wr_last    (wr_last),
      .wr_abort   (wr_abort),
      .full       (full),
      .afull      (afull),
      .overflow   (overflow),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_last    (rd_last),
      .rd_valid   (rd_valid),
      .empty      (empty),
      .frame_count(frame_count),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en    = 1'b0;
      wr_last  = 1'b0;
      wr_abort = 1'b0;
      rd_en    = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d, input logic l);
      wr_en   = 1'b1;
      wr_data = d;
      wr_last = l;
      step();
      wr_en   = 1'b0;
      wr_last = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      idle();
      wr_data = 8'h00;
      rst     = 1'b1;
      #1;
      n_checks++;
      if ({rd_valid, rd_last, rd_data, overflow} !== 11'b0) begin
         n_fail++;
         $display("FAIL reset_rd: got v=%b l=%b d=%h ovf=%b, expected all 0",
                  rd_valid, rd_last, rd_data, overflow);
      end
      n_checks++;
      if ({empty, full, afull, level, frame_count} !== {3'b100, 8'd0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_flags: got empty=%b full=%b afull=%b level=%0d fc=%0d, expected 1 0 0 0 0",
                  empty, full, afull, level, frame_count);
      end
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_basic_frame();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'hA1;
      exp_d[1] = 8'hA2;
      exp_d[2] = 8'hA3;
      wr(8'hA1, 1'b0);
      wr(8'hA2, 1'b0);
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_uncommitted_empty: got %b expected 1", empty);
      end
      wr(8'hA3, 1'b1);
      n_checks++;
      if (empty !== 1'b0 || frame_count !== 8'd1) begin
         n_fail++;
         $display("FAIL basic_commit: got empty=%b fc=%0d expected empty=0 fc=1", empty, frame_count);
      end
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_d[i] || rd_last !== (i == 2)) begin
            n_fail++;
            $display("FAIL basic_read%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                     i, rd_valid, rd_data, rd_last, exp_d[i], (i == 2));
         end
      end
      rd_en = 1'b0;
      n_checks++;
      if (frame_count !== 8'd0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_drained: got fc=%0d empty=%b expected fc=0 empty=1", frame_count, empty);
      end
      step();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== 8'hA3 || rd_last !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_hold: got v=%b d=%h l=%b expected v=0 d=a3 l=1", rd_valid, rd_data, rd_last);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_abort();
      for (int i = 0; i < 5; i++) begin
         wr(8'h10 + 8'(i), 1'b0);
         n_checks++;
         if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_empty%0d: got %b expected 1", i, empty);
         end
      end
      n_checks++;
      if (level !== 8'd5) begin
         n_fail++;
         $display("FAIL abort_level_pre: got %0d expected 5", level);
      end
      wr_abort = 1'b1;
      step();
      wr_abort = 1'b0;
      n_checks++;
      if (level !== 8'd0 || frame_count !== 8'd0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_state: got level=%0d fc=%0d empty=%b expected 0 0 1", level, frame_count, empty);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_read_empty: got rd_valid=%b expected 0", rd_valid);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_overflow();
      for (int i = 0; i < 128; i++) begin
         wr(8'(i), 1'b0);
         if (i == 118 || i == 119) begin
            n_checks++;
            if (afull !== (i == 119)) begin
               n_fail++;
               $display("FAIL ovf_afull_lvl%0d: got %b expected %b", i + 1, afull, (i == 119));
            end
         end
         if (i == 126 || i == 127) begin
            n_checks++;
            if (full !== (i == 127)) begin
               n_fail++;
               $display("FAIL ovf_full_lvl%0d: got %b expected %b", i + 1, full, (i == 127));
            end
         end
      end
      n_checks++;
      if (level !== 8'd128 || afull !== 1'b1 || empty !== 1'b1 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_filled: got level=%0d afull=%b empty=%b ovf=%b expected 128 1 1 0",
                  level, afull, empty, overflow);
      end
      wr(8'hEE, 1'b0);
      n_checks++;
      if (overflow !== 1'b1 || level !== 8'd128) begin
         n_fail++;
         $display("FAIL ovf_pulse: got ovf=%b level=%0d expected 1 128", overflow, level);
      end
      step();
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_pulse_end: got %b expected 0", overflow);
      end
      wr(8'hEF, 1'b1);
      n_checks++;
      if (level !== 8'd0 || frame_count !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_discard: got level=%0d fc=%0d empty=%b full=%b expected 0 0 1 0",
                  level, frame_count, empty, full);
      end
      step();
   endtask

   // -------------------------------------------------------------------------
   // Frame A: 100 bytes 0..99. Frame B: 60 bytes 0x80..0xBB, written while A
   // is read out, so both pointers wrap past 127.
   task automatic test_wrap();
      for (int i = 0; i < 100; i++) wr(8'(i), (i == 99));
      n_checks++;
      if (frame_count !== 8'd1 || level !== 8'd100) begin
         n_fail++;
         $display("FAIL wrap_fc1: got fc=%0d level=%0d expected 1 100", frame_count, level);
      end
      rd_en = 1'b1;
      for (int k = 0; k < 100; k++) begin
         wr_en   = (k < 60);
         wr_data = 8'h80 + 8'(k);
         wr_last = (k == 59);
         step();
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(k) || rd_last !== (k == 99)) begin
            n_fail++;
            $display("FAIL wrap_a%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                     k, rd_valid, rd_data, rd_last, 8'(k), (k == 99));
         end
         if (k == 59) begin
            n_checks++;
            if (frame_count !== 8'd2) begin
               n_fail++;
               $display("FAIL wrap_fc2: got %0d expected 2", frame_count);
            end
         end
      end
      wr_en   = 1'b0;
      wr_last = 1'b0;
      n_checks++;
      if (frame_count !== 8'd1) begin
         n_fail++;
         $display("FAIL wrap_fc1b: got %0d expected 1", frame_count);
      end
      for (int j = 0; j < 60; j++) begin
         step();
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'h80 + 8'(j) || rd_last !== (j == 59)) begin
            n_fail++;
            $display("FAIL wrap_b%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                     j, rd_valid, rd_data, rd_last, 8'h80 + 8'(j), (j == 59));
         end
      end
      rd_en = 1'b0;
      n_checks++;
      if (frame_count !== 8'd0 || empty !== 1'b1 || level !== 8'd0) begin
         n_fail++;
         $display("FAIL wrap_end: got fc=%0d empty=%b level=%0d expected 0 1 0", frame_count, empty, level);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_back_to_back();
      wr(8'h11, 1'b0);
      wr(8'h12, 1'b1);
      wr(8'h21, 1'b0);
      rd_en = 1'b1;
      step();
      n_checks++;
      if (rd_data !== 8'h11 || frame_count !== 8'd1) begin
         n_fail++;
         $display("FAIL b2b_first: got d=%h fc=%0d expected 11 1", rd_data, frame_count);
      end
      // Commit frame B in the same cycle frame A's last byte is read.
      wr_en   = 1'b1;
      wr_data = 8'h22;
      wr_last = 1'b1;
      step();
      wr_en   = 1'b0;
      wr_last = 1'b0;
      n_checks++;
      if (rd_data !== 8'h12 || rd_last !== 1'b1 || frame_count !== 8'd1) begin
         n_fail++;
         $display("FAIL b2b_same_cycle: got d=%h l=%b fc=%0d expected 12 1 1", rd_data, rd_last, frame_count);
      end
      step();
      n_checks++;
      if (rd_data !== 8'h21 || rd_last !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_b0: got d=%h l=%b expected 21 0", rd_data, rd_last);
      end
      step();
      rd_en = 1'b0;
      n_checks++;
      if (rd_data !== 8'h22 || rd_last !== 1'b1 || frame_count !== 8'd0) begin
         n_fail++;
         $display("FAIL b2b_b1: got d=%h l=%b fc=%0d expected 22 1 0", rd_data, rd_last, frame_count);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_mid_reset();
      wr(8'h31, 1'b0);
      wr(8'h32, 1'b0);
      wr(8'h33, 1'b1);
      wr(8'h41, 1'b0);
      rd_en = 1'b1;
      step();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h31) begin
         n_fail++;
         $display("FAIL mrst_pre: got v=%b d=%h expected 1 31", rd_valid, rd_data);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({rd_valid, rd_last, rd_data, overflow} !== 11'b0) begin
         n_fail++;
         $display("FAIL mrst_rd: got v=%b l=%b d=%h ovf=%b expected all 0", rd_valid, rd_last, rd_data, overflow);
      end
      n_checks++;
      if ({empty, full, afull, level, frame_count} !== {3'b100, 8'd0, 8'd0}) begin
         n_fail++;
         $display("FAIL mrst_flags: got empty=%b full=%b afull=%b level=%0d fc=%0d expected 1 0 0 0 0",
                  empty, full, afull, level, frame_count);
      end
      idle();
      step();
      rst = 1'b0;
      step();
      wr(8'h51, 1'b0);
      wr(8'h52, 1'b1);
      n_checks++;
      if (frame_count !== 8'd1 || level !== 8'd2) begin
         n_fail++;
         $display("FAIL mrst_new_commit: got fc=%0d level=%0d expected 1 2", frame_count, level);
      end
      rd_en = 1'b1;
      step();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h51 || rd_last !== 1'b0) begin
         n_fail++;
         $display("FAIL mrst_rd0: got v=%b d=%h l=%b expected 1 51 0", rd_valid, rd_data, rd_last);
      end
      step();
      rd_en = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h52 || rd_last !== 1'b1 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL mrst_rd1: got v=%b d=%h l=%b empty=%b expected 1 52 1 1",
                  rd_valid, rd_data, rd_last, empty);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_abort();
      test_overflow();
      test_wrap();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
